// File: rtl/eth_tx_arbiter.sv
// Purpose : round-robin arbiter sharing one MAC TX path between NUM_PORTS frame sources.
// Latency : grant is registered 1 cycle after IDLE sees req with tx_ready; tx_* are registered copies (1 cycle).
// Backpr. : no grant while tx_ready=0; after a frame, waits for the MAC to go busy and return ready.
//
// Ports:
//   clk, reset            MAC TX clock, asynchronous active-high reset
//   req / grant           per-port request, one-hot registered grant
//   in_start/in_data_valid/in_last/in_data   per-port frame beats (port p byte at [8p+7:8p])
//   tx_ready              MAC flow control (low while the MAC is sending preamble/data/pad/CRC/IFG)
//   tx_start/tx_data_valid/tx_data          forwarded beats to the MAC
//   busy                  high whenever the arbiter is not IDLE
//   timeout_err           sticky watchdog flag
//
// Optional macro ETH_TX_ARB_WATCHDOG_EN: adds a 12-bit watchdog that ends a granted frame after
// TIMEOUT cycles and sets timeout_err. Without it GRANTED waits indefinitely and timeout_err is 0.

module eth_tx_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 4095
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   req,
  output logic [NUM_PORTS-1:0]   grant,
  input  logic [NUM_PORTS-1:0]   in_start,
  input  logic [NUM_PORTS-1:0]   in_data_valid,
  input  logic [NUM_PORTS-1:0]   in_last,
  input  logic [8*NUM_PORTS-1:0] in_data,
  input  logic                   tx_ready,
  output logic                   tx_start,
  output logic                   tx_data_valid,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [NUM_PORTS-1:0] GRANT_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] last_grant;   // also the currently granted port while in GRANTED
  logic          started;      // a start has been forwarded for the current grant
  logic          seen_busy;    // MAC dropped tx_ready after that start

  // Per-port byte lanes
  logic [7:0] port_data [NUM_PORTS];
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign port_data[p] = in_data[8*p +: 8];
  end

  // Round-robin pick: first requester searching upward from last_grant+1
  logic [PW-1:0] pick;
  logic [PW-1:0] cand;
  logic          pick_vld;

  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = PW'((int'(last_grant) + i) % NUM_PORTS);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Granted-port view and frame events
  logic cur_req, cur_start, cur_dv, cur_last;
  logic cancel, beat_fwd, frame_end;

  always_comb begin
    cur_req   = req[last_grant];
    cur_start = in_start[last_grant];
    cur_dv    = in_data_valid[last_grant];
    cur_last  = in_last[last_grant];
    // A request withdrawn before any start abandons the grant.
    cancel    = !cur_req && !started;
    // Data before the first start, or alongside a start, is dropped.
    beat_fwd  = !cancel && cur_dv && started && !cur_start;
    // in_last wins over a simultaneous req drop because started is already set.
    frame_end = beat_fwd && cur_last;
  end

  assign busy = (state != IDLE);

`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam logic [11:0] WD_LIMIT = 12'(TIMEOUT - 1);
  logic [11:0] wd_cnt;
`else
  logic [11:0] unused_timeout;
  assign unused_timeout = 12'(TIMEOUT);
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= PW'(NUM_PORTS - 1);
      started       <= 1'b0;
      seen_busy     <= 1'b0;
      tx_start      <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_data       <= '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      wd_cnt        <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      tx_start      <= 1'b0;
      tx_data_valid <= 1'b0;

      // Any ready-low cycle after the forwarded start counts, even while still GRANTED.
      if (started && !tx_ready) begin
        seen_busy <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tx_ready && pick_vld) begin
            grant      <= GRANT_ONE << pick;
            last_grant <= pick;
            started    <= 1'b0;
            seen_busy  <= 1'b0;
            state      <= GRANTED;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            wd_cnt     <= '0;
`endif
          end
        end

        GRANTED: begin
          if (cancel) begin
            grant <= '0;
            state <= IDLE;
          end else begin
            if (cur_start) begin
              tx_start <= 1'b1;
              started  <= 1'b1;
            end
            if (beat_fwd) begin
              tx_data_valid <= 1'b1;
              tx_data       <= port_data[last_grant];
            end
            if (frame_end) begin
              grant <= '0;
              state <= DRAIN;
            end
`ifdef ETH_TX_ARB_WATCHDOG_EN
            else if (wd_cnt == WD_LIMIT) begin
              grant       <= '0;
              timeout_err <= 1'b1;
              state       <= (started || cur_start) ? DRAIN : IDLE;
            end else begin
              wd_cnt <= wd_cnt + 12'd1;
            end
`endif
          end
        end

        DRAIN: begin
          if (seen_busy && tx_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Purpose : directed self-checking bench for eth_tx_arbiter (4 ports).
// Latency : inputs driven 1 ns after a rising edge, outputs sampled 1 ns after the next one.
// Backpr. : a simple MAC model lowers tx_ready for a few cycles after each frame.

module tb_eth_tx_arbiter;

`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam int TB_TIMEOUT = 50;
`else
  localparam int TB_TIMEOUT = 4095;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic [3:0]  in_start;
  logic [3:0]  in_data_valid;
  logic [3:0]  in_last;
  logic [31:0] in_data;
  logic        tx_ready;
  logic        tx_start;
  logic        tx_data_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  eth_tx_arbiter #(.NUM_PORTS(4), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .grant         (grant),
    .in_start      (in_start),
    .in_data_valid (in_data_valid),
    .in_last       (in_last),
    .in_data       (in_data),
    .tx_ready      (tx_ready),
    .tx_start      (tx_start),
    .tx_data_valid (tx_data_valid),
    .tx_data       (tx_data),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not finish in time");
    $fatal(1, "bench time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req           = '0;
    in_start      = '0;
    in_data_valid = '0;
    in_last       = '0;
    in_data       = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    tx_ready = 1'b1;
    reset    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Stimulus only: waits for a grant, sends start + nbytes on port p if granted,
  // then holds tx_ready low for 5 cycles and counts cycles with any grant.
  task automatic send_frame(input logic [1:0] p, input int nbytes,
                            output logic [3:0] g_seen, output int grants_while_busy);
    int n;
    n = 0;
    grants_while_busy = 0;
    while (grant == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    g_seen = grant;
    if (grant[p]) begin
      in_start[p] = 1'b1;
      tick();
      in_start[p] = 1'b0;
      for (int i = 1; i <= nbytes; i++) begin
        in_data_valid[p]          = 1'b1;
        in_data[{p, 3'b000} +: 8] = 8'(i);
        in_last[p]                = (i == nbytes);
        tick();
      end
      in_data_valid[p] = 1'b0;
      in_last[p]       = 1'b0;
    end
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (grant !== 4'b0000) grants_while_busy++;
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    tx_ready = 1'b1;
    reset    = 1'b1;
    #3;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
    total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_dv got=%b exp=0", tx_data_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    int busy_bad;
    do_reset();
    // A non-granted port chattering on its strobes must be ignored.
    in_data_valid[1] = 1'b1;
    in_data[15:8]    = 8'hEE;
    req[0]           = 1'b1;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", grant); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_granted got=%b exp=1", busy); end
    in_start[0] = 1'b1;
    tick();
    in_start[0] = 1'b0;
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_tx_start got=%b exp=1", tx_start); end
    total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL single_no_dv_with_start got=%b exp=0", tx_data_valid); end
    for (int i = 1; i <= 60; i++) begin
      in_data_valid[0] = 1'b1;
      in_data[7:0]     = 8'(i + 8'h40);
      in_last[0]       = (i == 60);
      tick();
      total++;
      if (tx_data_valid !== 1'b1 || tx_data !== 8'(i + 8'h40) || tx_start !== 1'b0) begin
        bad++;
        $display("FAIL single_byte%0d got dv=%b data=%h start=%b exp dv=1 data=%h start=0",
                 i, tx_data_valid, tx_data, tx_start, 8'(i + 8'h40));
      end
    end
    in_data_valid = '0;
    in_last       = '0;
    req           = '0;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_grant_clear got=%b exp=0000", grant); end
    tick();
    total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL single_dv_pulse got=%b exp=0", tx_data_valid); end
    tx_ready = 1'b0;
    busy_bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b1 || grant !== 4'b0000) busy_bad++;
    end
    total++; if (busy_bad !== 0) begin bad++; $display("FAIL single_drain_hold bad_cycles=%0d exp=0", busy_bad); end
    tx_ready = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [6];
    logic [3:0] g;
    int         gb;
    order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    do_reset();
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      send_frame(order[k], 4, g, gb);
      total++;
      if (g !== (4'b0001 << order[k])) begin
        bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, g, 4'b0001 << order[k]);
      end
      total++;
      if (gb !== 0) begin bad++; $display("FAIL rr_busy_grant%0d got=%0d exp=0", k, gb); end
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_hold_off();
    int early;
    do_reset();
    tx_ready = 1'b0;
    req      = 4'b0010;
    early    = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (grant !== 4'b0000) early++;
    end
    total++; if (early !== 0) begin bad++; $display("FAIL hold_no_grant got=%0d exp=0", early); end
    tx_ready = 1'b1;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL hold_grant got=%b exp=0010", grant); end
    req = '0;
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL hold_cancel got=%b exp=0000", grant); end
    req = 4'b0110;
    tick();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL hold_rr_after1 got=%b exp=0100", grant); end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_cancel();
    int starts;
    do_reset();
    req = 4'b0010;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL cancel_grant1 got=%b exp=0010", grant); end
    req    = 4'b0100;
    starts = 0;
    tick();
    if (tx_start !== 1'b0) starts++;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL cancel_clear got=%b exp=0000", grant); end
    tick();
    if (tx_start !== 1'b0) starts++;
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL cancel_next_grant got=%b exp=0100", grant); end
    total++; if (starts !== 0) begin bad++; $display("FAIL cancel_no_start got=%0d exp=0", starts); end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0001;
    tick();
    in_data_valid[0] = 1'b1;
    in_data[7:0]     = 8'h55;
    tick();
    total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL sim_dv_before_start got=%b exp=0", tx_data_valid); end
    in_start[0] = 1'b1;
    tick();
    total++;
    if (tx_start !== 1'b1 || tx_data_valid !== 1'b0) begin
      bad++; $display("FAIL sim_start_with_dv got start=%b dv=%b exp start=1 dv=0", tx_start, tx_data_valid);
    end
    in_data_valid[0] = 1'b0;
    tick();
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL sim_repeat_start got=%b exp=1", tx_start); end
    in_start[0]      = 1'b0;
    in_data_valid[0] = 1'b1;
    in_last[0]       = 1'b1;
    in_data[7:0]     = 8'h77;
    req              = '0;
    tick();
    in_data_valid = '0;
    in_last       = '0;
    total++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h77 || tx_start !== 1'b0) begin
      bad++; $display("FAIL sim_last_beat got dv=%b data=%h start=%b exp dv=1 data=77 start=0",
                      tx_data_valid, tx_data, tx_start);
    end
    total++;
    if (grant !== 4'b0000 || busy !== 1'b1) begin
      bad++; $display("FAIL sim_last_wins got grant=%b busy=%b exp grant=0000 busy=1", grant, busy);
    end
    tick();
    tick();
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sim_drain_wait got=%b exp=1", busy); end
    tx_ready = 1'b0;
    tick();
    tx_ready = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL sim_drain_exit got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    req = 4'b0001;
    tick();
    in_start[0] = 1'b1;
    tick();
    in_start[0] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      in_data_valid[0] = 1'b1;
      in_data[7:0]     = 8'(i);
      tick();
    end
    total++; if (tx_data_valid !== 1'b1) begin bad++; $display("FAIL mid_byte10_dv got=%b exp=1", tx_data_valid); end
    reset = 1'b1;
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL mid_reset_grant got=%b exp=0000", grant); end
    total++; if (tx_data_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_dv got=%b exp=0", tx_data_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
    clear_inputs();
    req = 4'b1001;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_port0_priority got=%b exp=0001", grant); end
    req = '0;
    tick();
    tick();
  endtask

`ifdef ETH_TX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    logic [3:0] g;
    int         gb;
    do_reset();
    req = 4'b0001;
    tick();
    in_start[0] = 1'b1;
    tick();
    in_start[0] = 1'b0;
    for (int i = 0; i < 48; i++) tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wd_still_granted got=%b exp=0001", grant); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_err_early got=%b exp=0", timeout_err); end
    tick();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL wd_grant_clear got=%b exp=0000", grant); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_err_set got=%b exp=1", timeout_err); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wd_drain got=%b exp=1", busy); end
    req      = '0;
    tx_ready = 1'b0;
    tick();
    tx_ready = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wd_drain_exit got=%b exp=0", busy); end
    req = 4'b0001;
    send_frame(2'd0, 4, g, gb);
    req = '0;
    total++; if (g !== 4'b0001) begin bad++; $display("FAIL wd_next_grant got=%b exp=0001", g); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_err_sticky got=%b exp=1", timeout_err); end
    tick();
    tick();
  endtask
`endif

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b1;
    clear_inputs();
    test_reset();
    test_single_frame();
    test_round_robin();
    test_hold_off();
    test_cancel();
    test_simultaneous();
    test_reset_mid_frame();
`ifdef ETH_TX_ARB_WATCHDOG_EN
    test_watchdog();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Round-robin arbiter sharing one tri-speed MAC TX path between NUM_PORTS frame sources (e.g. ARP, ICMP, UDP engines).
- Grants one requester at a time and forwards its start/data beats to the MAC TX bus, one registered stage.
- Holds off the next grant until the MAC has gone busy (tx_ready low) and returned to ready, covering preamble, padding, CRC and IFG at 10/100/1000.

Parameters:
- NUM_PORTS, 4: number of requesters, 2..8.
- TIMEOUT, 4095: watchdog limit in clk cycles for a granted frame; used only with the optional feature.

Ports:
- clk  in  1  MAC TX clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_PORTS  per-port request; held until the frame's last beat or a cancel
- grant  out  NUM_PORTS  one-hot grant, registered
- in_start  in  NUM_PORTS  per-port frame start pulse
- in_data_valid  in  NUM_PORTS  per-port byte strobe
- in_last  in  NUM_PORTS  per-port strobe, valid only with in_data_valid, marking the final byte
- in_data  in  8*NUM_PORTS  per-port byte, port p at [8p+7:8p]
- tx_ready  in  1  MAC flow control
- tx_start  out  1  to MAC
- tx_data_valid  out  1  to MAC
- tx_data  out  8  to MAC
- busy  out  1  high whenever state is not IDLE
- timeout_err  out  1  sticky watchdog flag; held at 0 without the optional feature

Behaviour:
- Reset (async): state IDLE; grant=0; tx_start=0, tx_data_valid=0, tx_data=0; busy=0; timeout_err=0; last_grant=NUM_PORTS-1, so port 0 has first priority.
- Outputs of non-granted ports are ignored. tx_start and tx_data_valid are single-cycle pulses.
- Datapath: tx_start, tx_data_valid and tx_data are registered copies of the granted port's inputs, with 1 cycle latency.
- IDLE:
  - Advances when tx_ready=1 and req!=0.
  - Picks the first requesting port searching upward from last_grant+1, modulo NUM_PORTS.
  - Next cycle: grant[p]=1, last_grant=p, started=0, seen_busy=0, state GRANTED.
  - If tx_ready=0, the arbiter waits in IDLE.
- GRANTED:
  - req[p]=0 before any in_start[p]: cancel. grant clears next cycle, state returns to IDLE, nothing is forwarded.
  - in_start[p]: forwarded and sets started. A repeated start is forwarded again (the MAC flushes its FIFO); state is unchanged.
  - in_data_valid[p] before started: dropped.
  - in_data_valid[p] & in_last[p] & started: forwarded. grant clears next cycle and state goes to DRAIN.
- DRAIN:
  - Waits until seen_busy=1 and tx_ready=1, then goes to IDLE.
  - seen_busy sets on any cycle with tx_ready=0 after the forwarded start, including cycles while in GRANTED.
  - This ensures the MAC has begun the frame before the next grant; at 10M it may take up to 100 cycles for tx_ready to drop.
- Simultaneous events:
  - in_last with req falling in the same cycle: treated as frame completion, not a cancel.
  - in_start with in_data_valid in the same cycle: start is forwarded, the data beat is dropped.
- Fairness: a port requesting back-to-back is always re-served after every other requesting port has had one grant.

Optional Feature:
- Macro: ETH_TX_ARB_WATCHDOG_EN.
- Defined:
  - A 12-bit counter clears on grant and increments every cycle in GRANTED.
  - On reaching TIMEOUT: grant clears, state goes to DRAIN if started, else to IDLE.
  - timeout_err is set to 1 and cleared only by reset.
- Undefined: no counter; GRANTED waits indefinitely; timeout_err is tied to 0.

Test Plan:
- Single frame: port 0 requests; start plus 60 bytes, last on byte 60. Required: tx_* mirror the inputs 1 cycle later. After in_last, grant clears. Model the MAC as tx_ready=0 for 100 cycles, then 1; busy must drop the cycle after tx_ready rises.
- Round robin: ports 0, 1, 3 request continuously. Required grant order 0,1,3,0,1,3; no grant overlap; no second grant while tx_ready=0.
- Hold-off: tx_ready=0 at req. Required: no grant until tx_ready=1. Then raise req[2] and req[1] together with last_grant=1; grant[2] must win.
- Cancel: grant port 1, drop req[1] without a start. Required: no tx_start pulse, grant clears, and port 2 is granted within 2 cycles.
- Reset mid-frame: assert reset during byte 10. Required: immediate grant=0, tx_data_valid=0, busy=0; after release, port 0 has priority.
- Watchdog (ETH_TX_ARB_WATCHDOG_EN, TIMEOUT=50): granted port sends start and no last. Required: grant clears 50 cycles after grant, timeout_err=1, DRAIN is entered, and timeout_err stays 1 through later frames.
